// File: rtl/axis_rr_arbiter.sv
// Two-source AXI-Stream packet arbiter with round-robin tie breaking.
// A grant is held for a whole packet and released only after its tlast beat transfers.
module axis_rr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                  s0_axis_tvalid,
  input  logic                  s0_axis_tlast,
  output logic                  s0_axis_tready,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                  s1_axis_tvalid,
  input  logic                  s1_axis_tlast,
  output logic                  s1_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tid,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [CNT_WIDTH-1:0]  pkt_cnt0,
  output logic [CNT_WIDTH-1:0]  pkt_cnt1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_grant;
  logic   xfer;
  logic   pkt_done;

  assign xfer     = m_axis_tvalid & m_axis_tready;
  assign pkt_done = xfer & m_axis_tlast;

  // Arbitration is only evaluated in IDLE, so every packet costs one bubble cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (enable) begin
          if (s0_axis_tvalid && s1_axis_tvalid)
            state_next = last_grant ? GRANT0 : GRANT1;
          else if (s0_axis_tvalid)
            state_next = GRANT0;
          else if (s1_axis_tvalid)
            state_next = GRANT1;
        end
      end
      GRANT0:  if (pkt_done) state_next = IDLE;
      GRANT1:  if (pkt_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m_axis_tdata   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    m_axis_tid     = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    busy           = 1'b0;
    unique case (state)
      GRANT0: begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tlast   = s0_axis_tlast;
        s0_axis_tready = m_axis_tready;
        busy           = 1'b1;
      end
      GRANT1: begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tlast   = s1_axis_tlast;
        s1_axis_tready = m_axis_tready;
        m_axis_tid     = 1'b1;
        busy           = 1'b1;
      end
      default: ;
    endcase
  end

  // last_grant resets to 1 so that source 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      if (pkt_done)
        last_grant <= (state == GRANT1);
    end
  end

  // The IDLE bubble following a tlast beat is where the beat counter clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt <= '0;
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (xfer) begin
        if (beat_cnt != '1)
          beat_cnt <= beat_cnt + CNT_WIDTH'(1);
      end else if (state == IDLE) begin
        beat_cnt <= '0;
      end
      if (pkt_done && state == GRANT0)
        pkt_cnt0 <= pkt_cnt0 + CNT_WIDTH'(1);
      if (pkt_done && state == GRANT1)
        pkt_cnt1 <= pkt_cnt1 + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: packet queues per source plus a packet-level
// ownership model; a negedge monitor compares every cycle against them.
module tb_axis_rr_arbiter;

  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = 1 << CW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [DW-1:0] s0_axis_tdata;
  logic          s0_axis_tvalid;
  logic          s0_axis_tlast;
  logic          s0_axis_tready;
  logic [DW-1:0] s1_axis_tdata;
  logic          s1_axis_tvalid;
  logic          s1_axis_tlast;
  logic          s1_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic          m_axis_tid;
  logic          busy;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] pkt_cnt0;
  logic [CW-1:0] pkt_cnt1;

  int total = 0;
  int bad   = 0;

  beat_t tx0_q[$];
  beat_t tx1_q[$];
  beat_t exp0_q[$];
  beat_t exp1_q[$];
  int    dut_log[$];

  int owner      = -1;
  int last_grant = 1;
  int beats      = 0;
  int pk0        = 0;
  int pk1        = 0;
  bit clear_pending = 0;
  bit prev_busy     = 0;

  axis_rr_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .s0_axis_tdata  (s0_axis_tdata),
    .s0_axis_tvalid (s0_axis_tvalid),
    .s0_axis_tlast  (s0_axis_tlast),
    .s0_axis_tready (s0_axis_tready),
    .s1_axis_tdata  (s1_axis_tdata),
    .s1_axis_tvalid (s1_axis_tvalid),
    .s1_axis_tlast  (s1_axis_tlast),
    .s1_axis_tready (s1_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tid     (m_axis_tid),
    .busy           (busy),
    .beat_cnt       (beat_cnt),
    .pkt_cnt0       (pkt_cnt0),
    .pkt_cnt1       (pkt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void checkOutput(input string name, input logic [31:0] actual,
                                      input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endfunction

  // Ownership follows the arbitration rules at packet granularity; beats come from queues.
  always @(negedge clk) begin
    beat_t e;
    bit    v0;
    bit    v1;
    bit    xfer;
    if (reset) begin
      owner = -1; last_grant = 1; beats = 0; pk0 = 0; pk1 = 0;
      clear_pending = 0; prev_busy = 0;
    end else begin
      v0 = s0_axis_tvalid;
      v1 = s1_axis_tvalid;
      checkOutput("busy", 32'(busy), 32'(owner >= 0));
      checkOutput("tid", 32'(m_axis_tid), 32'(owner == 1));
      checkOutput("beat_cnt", 32'(beat_cnt), beats);
      checkOutput("pkt_cnt0", 32'(pkt_cnt0), pk0);
      checkOutput("pkt_cnt1", 32'(pkt_cnt1), pk1);
      if (owner < 0) begin
        checkOutput("idle_tvalid", 32'(m_axis_tvalid), 0);
        checkOutput("idle_tlast", 32'(m_axis_tlast), 0);
        checkOutput("idle_tdata", m_axis_tdata, 0);
        checkOutput("idle_s0_tready", 32'(s0_axis_tready), 0);
        checkOutput("idle_s1_tready", 32'(s1_axis_tready), 0);
      end else begin
        checkOutput("m_tvalid", 32'(m_axis_tvalid), 32'(owner == 0 ? v0 : v1));
        checkOutput("own_tready", 32'(owner == 0 ? s0_axis_tready : s1_axis_tready),
                    32'(m_axis_tready));
        checkOutput("other_tready", 32'(owner == 0 ? s1_axis_tready : s0_axis_tready), 0);
      end
      if (busy && !prev_busy) dut_log.push_back(int'(m_axis_tid));
      prev_busy = busy;

      xfer = (owner >= 0) && (owner == 0 ? v0 : v1) && m_axis_tready;
      if (clear_pending) begin
        beats = 0;
        clear_pending = 0;
      end
      if (xfer) begin
        if (owner == 0 && exp0_q.size() > 0) e = exp0_q.pop_front();
        else if (owner == 1 && exp1_q.size() > 0) e = exp1_q.pop_front();
        else begin
          total++; bad++;
          $display("[TB] FAIL unexpected_beat: got a beat from source %0d expected none at %0t",
                   owner, $time);
          e.data = '0; e.last = 1'b1;
        end
        checkOutput("m_tdata", m_axis_tdata, e.data);
        checkOutput("m_tlast", 32'(m_axis_tlast), 32'(e.last));
        beats = (beats < CMAX - 1) ? beats + 1 : CMAX - 1;
        if (e.last) begin
          if (owner == 0) pk0 = (pk0 + 1) % CMAX;
          else pk1 = (pk1 + 1) % CMAX;
          last_grant = owner;
          owner = -1;
          clear_pending = 1;
        end
      end else if (owner < 0 && enable && (v0 || v1)) begin
        owner = (v0 && v1) ? 1 - last_grant : (v0 ? 0 : 1);
      end
    end
  end

  task automatic queue_packet(input int src, input int len, input int base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = (base >= 0) ? DW'(base + i) : DW'($urandom);
      b.last = (i == len - 1);
      if (src == 0) begin tx0_q.push_back(b); exp0_q.push_back(b); end
      else begin tx1_q.push_back(b); exp1_q.push_back(b); end
    end
  endtask

  // One clock of source/sink driving; handshakes are sampled at the negedge before the edge.
  task automatic applyStimulus(input bit rdy, input int vld_pct);
    bit f0;
    bit f1;
    @(negedge clk);
    f0 = s0_axis_tvalid & s0_axis_tready;
    f1 = s1_axis_tvalid & s1_axis_tready;
    @(posedge clk);
    #1;
    if (f0 && tx0_q.size() > 0) void'(tx0_q.pop_front());
    if (f1 && tx1_q.size() > 0) void'(tx1_q.pop_front());
    if (tx0_q.size() > 0 && int'($urandom % 100) < vld_pct) begin
      s0_axis_tvalid = 1'b1; s0_axis_tdata = tx0_q[0].data; s0_axis_tlast = tx0_q[0].last;
    end else begin
      s0_axis_tvalid = 1'b0; s0_axis_tdata = $urandom; s0_axis_tlast = 1'($urandom);
    end
    if (tx1_q.size() > 0 && int'($urandom % 100) < vld_pct) begin
      s1_axis_tvalid = 1'b1; s1_axis_tdata = tx1_q[0].data; s1_axis_tlast = tx1_q[0].last;
    end else begin
      s1_axis_tvalid = 1'b0; s1_axis_tdata = $urandom; s1_axis_tlast = 1'($urandom);
    end
    m_axis_tready = rdy;
  endtask

  task automatic run_until_done(input int budget, input int mode, input int vld_pct,
                                input string tag);
    int cyc = 0;
    bit rdy;
    while (!(tx0_q.size() == 0 && tx1_q.size() == 0 && exp0_q.size() == 0 &&
             exp1_q.size() == 0 && busy == 1'b0)) begin
      if (cyc >= budget) begin
        total++; bad++;
        $display("[TB] FAIL timeout_%s: got %0d cycles without draining, expected under %0d",
                 tag, cyc, budget);
        return;
      end
      if (mode == 1) rdy = 1'b1;
      else if (mode == 2) rdy = (cyc % 12) < 8;
      else rdy = ($urandom % 100) < 70;
      applyStimulus(rdy, vld_pct);
      cyc++;
    end
  endtask

  task automatic wait_exp(input int src, input int level, input int budget, input string tag);
    int cyc = 0;
    while ((src == 0 ? exp0_q.size() : exp1_q.size()) > level) begin
      if (cyc >= budget) begin
        total++; bad++;
        $display("[TB] FAIL timeout_%s: got %0d cycles, expected under %0d", tag, cyc, budget);
        return;
      end
      applyStimulus(1'b1, 100);
      cyc++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_tid"}, 32'(m_axis_tid), 0);
    checkOutput({tag, "_tvalid"}, 32'(m_axis_tvalid), 0);
    checkOutput({tag, "_s0_tready"}, 32'(s0_axis_tready), 0);
    checkOutput({tag, "_s1_tready"}, 32'(s1_axis_tready), 0);
    checkOutput({tag, "_beat_cnt"}, 32'(beat_cnt), 0);
    checkOutput({tag, "_pkt_cnt0"}, 32'(pkt_cnt0), 0);
    checkOutput({tag, "_pkt_cnt1"}, 32'(pkt_cnt1), 0);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1 check_reset_values("midreset");
    tx0_q.delete(); tx1_q.delete(); exp0_q.delete(); exp1_q.delete();
    s0_axis_tvalid = 1'b0;
    s1_axis_tvalid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #1000000;
    bad++;
    $display("[TB] FAIL watchdog: got no completion, expected finish before %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; m_axis_tready = 1'b0;
    s0_axis_tdata = '0; s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0;
    s1_axis_tdata = '0; s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0;
    #1 check_reset_values("por");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] round-robin with both sources valid");
    enable = 1'b1;
    dut_log.delete();
    queue_packet(0, 4, 100); queue_packet(1, 4, 200);
    queue_packet(0, 4, 300); queue_packet(1, 4, 400);
    run_until_done(200, 1, 100, "rr");
    checkOutput("rr_grants", dut_log.size(), 4);
    for (int i = 0; i < dut_log.size() && i < 4; i++)
      checkOutput("rr_order", dut_log[i], i % 2);
    checkOutput("rr_pkt_cnt0", 32'(pkt_cnt0), 2);
    checkOutput("rr_pkt_cnt1", 32'(pkt_cnt1), 2);

    $display("[TB] single 16-beat packet from source 1");
    dut_log.delete();
    queue_packet(1, 16, 0);
    run_until_done(100, 1, 100, "s1_long");
    checkOutput("s1_long_grant", dut_log.size() > 0 ? dut_log[0] : -1, 1);
    checkOutput("s1_long_pkt_cnt1", 32'(pkt_cnt1), 3);

    $display("[TB] backpressure 8 on / 4 off");
    queue_packet(0, 16, -1);
    run_until_done(200, 2, 100, "bp");
    checkOutput("bp_pkt_cnt0", 32'(pkt_cnt0), 3);

    $display("[TB] enable dropped mid-packet");
    queue_packet(0, 8, 500);
    wait_exp(0, 5, 50, "en_beat3");
    enable = 1'b0;
    queue_packet(1, 4, 600);
    repeat (20) applyStimulus(1'b1, 100);
    checkOutput("en_pkt_cnt0", 32'(pkt_cnt0), 4);
    checkOutput("en_idle_busy", 32'(busy), 0);
    checkOutput("en_idle_s1_tready", 32'(s1_axis_tready), 0);
    dut_log.delete();
    enable = 1'b1;
    run_until_done(100, 1, 100, "en_resume");
    checkOutput("en_resume_grant", dut_log.size() > 0 ? dut_log[0] : -1, 1);
    checkOutput("en_pkt_cnt1", 32'(pkt_cnt1), 4);

    $display("[TB] reset in the middle of a packet");
    queue_packet(0, 4, 700);
    run_until_done(100, 1, 100, "pre_reset");
    queue_packet(1, 8, 800);
    wait_exp(1, 3, 50, "reset_beat5");
    pulse_reset();
    dut_log.delete();
    queue_packet(0, 3, 900); queue_packet(1, 3, 1000);
    run_until_done(100, 1, 100, "post_reset");
    checkOutput("post_reset_first", dut_log.size() > 0 ? dut_log[0] : -1, 0);
    checkOutput("post_reset_second", dut_log.size() > 1 ? dut_log[1] : -1, 1);
    checkOutput("post_reset_pkt_cnt0", 32'(pkt_cnt0), 1);

    $display("[TB] packet counter wrap");
    for (int i = 0; i < CMAX; i++) queue_packet(0, 1, i);
    run_until_done(300, 1, 100, "wrap");
    checkOutput("wrap_pkt_cnt0", 32'(pkt_cnt0), 1);
    checkOutput("wrap_pkt_cnt1", 32'(pkt_cnt1), 1);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 1500; c++) begin
      if (tx0_q.size() < 4 && $urandom_range(0, 7) == 0)
        queue_packet(0, $urandom_range(1, 20), -1);
      if (tx1_q.size() < 4 && $urandom_range(0, 7) == 0)
        queue_packet(1, $urandom_range(1, 20), -1);
      applyStimulus(($urandom % 100) < 70, 80);
      enable = ($urandom % 10) != 0;
    end
    enable = 1'b1;
    run_until_done(3000, 0, 100, "random_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of all tdata ports.
REQ-002 Parameter: CNT_WIDTH, default 16, width of beat and packet counters.
REQ-003 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: enable  input  1  high = new grants permitted; low = no new grant, in-flight packet completes.
REQ-006 Port: s0_axis_tdata/tvalid/tlast  input  DATA_WIDTH/1/1  source 0 stream.
REQ-007 Port: s0_axis_tready  output  1  source 0 ready.
REQ-008 Port: s1_axis_tdata/tvalid/tlast  input  DATA_WIDTH/1/1  source 1 stream.
REQ-009 Port: s1_axis_tready  output  1  source 1 ready.
REQ-010 Port: m_axis_tdata/tvalid/tlast  output  DATA_WIDTH/1/1  merged stream toward the downstream register slice.
REQ-011 Port: m_axis_tready  input  1  downstream ready.
REQ-012 Port: m_axis_tid  output  1  index of the source currently granted.
REQ-013 Port: busy  output  1  high while a grant is held.
REQ-014 Port: beat_cnt  output  CNT_WIDTH  beats transferred in the current packet.
REQ-015 Port: pkt_cnt0, pkt_cnt1  output  CNT_WIDTH each  completed packets per source.

Function
REQ-016 FSM states: IDLE, GRANT0, GRANT1; state, last_grant, and all counters are registers.
REQ-017 IDLE, enable=1, exactly one sN_axis_tvalid=1: next state GRANTN.
REQ-018 IDLE, enable=1, both tvalid=1: grant the source not equal to last_grant (round-robin).
REQ-019 IDLE, enable=0 or no tvalid: remain IDLE.
REQ-020 Arbitration latency: grant takes effect the cycle after the IDLE decision; one idle bubble per packet.
REQ-021 GRANTN: m_axis_tdata/tvalid/tlast = sN values combinationally; sN_axis_tready = m_axis_tready; the other source's tready = 0.
REQ-022 IDLE: m_axis_tvalid=0, m_axis_tlast=0, both s tready=0, m_axis_tdata=0.
REQ-023 A beat is transferred when m_axis_tvalid & m_axis_tready = 1.
REQ-024 GRANTN: a transfer with tlast=1 moves the FSM to IDLE next cycle, sets last_grant=N, and increments pkt_cntN.
REQ-025 Grant is never released mid-packet; enable falling during GRANTN has no effect until tlast transfers.
REQ-026 sN tvalid dropping while granted: hold grant; no transfer that cycle.
REQ-027 beat_cnt increments on each transfer; saturates at all-ones; clears to 0 on the cycle after a tlast transfer.
REQ-028 pkt_cnt0/pkt_cnt1 wrap from all-ones to 0.
REQ-029 m_axis_tid = 0 in GRANT0 and IDLE, 1 in GRANT1; busy = 1 in GRANT0/GRANT1.
REQ-030 m_axis_tready=0 with data pending: no state or counter change.

Reset
REQ-031 reset=1 asynchronously forces state=IDLE, last_grant=1 (source 0 wins first tie), beat_cnt=0, pkt_cnt0=pkt_cnt1=0, busy=0, m_axis_tid=0, m_axis_tvalid=0, both s tready=0.
REQ-032 Reset asserted mid-packet aborts the packet; counters are not incremented for it; the first tie after release grants source 0.

Verification
REQ-033 Both sources continuously valid, 4-beat packets, m_axis_tready=1 -> grant order 0,1,0,1; m_axis_tid matches; one bubble between packets; pkt_cnt0=pkt_cnt1=2 after 4 packets.
REQ-034 Only s1 valid with a 16-beat packet (data 0..15) -> GRANT1 two cycles after tvalid, 16 beats out in order, beat_cnt reaches 16 then 0, pkt_cnt1=1.
REQ-035 m_axis_tready toggled 8 cycles on/4 off during a 16-beat packet -> no beat lost or duplicated; s tready mirrors m_axis_tready.
REQ-036 enable dropped at beat 3 of an 8-beat s0 packet, s1 valid -> s0 packet completes, FSM stays IDLE until enable=1, then grants s1.
REQ-037 reset pulsed at beat 5 of a packet -> all outputs at REQ-031 values immediately; next tie grants s0.
REQ-038 pkt_cnt0 preloaded via 2^CNT_WIDTH packets (CNT_WIDTH=4 build) -> pkt_cnt0 wraps 15 -> 0.
